// File: rtl/camera_move_ctrl_if.sv
// rtl/camera_move_ctrl_if.sv - key event inputs and render request outputs of the camera motion controller
interface camera_move_ctrl_if #(
    parameter int NUM_KEYS = 6,
    parameter int CNT_W    = 32,
    parameter int DIR_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
);
    logic                tick;
    logic                key_pressed;
    logic                key_released;
    logic [NUM_KEYS-1:0] key_vec;
    logic                rendering_done;
    logic                render_frame;
    logic [DIR_W-1:0]    move_dir;
    logic [CNT_W-1:0]    move_amt;
    logic                busy;

    modport master (
        output tick, key_pressed, key_released, key_vec, rendering_done,
        input  render_frame, move_dir, move_amt, busy
    );

    modport slave (
        input  tick, key_pressed, key_released, key_vec, rendering_done,
        output render_frame, move_dir, move_amt, busy
    );
endinterface

// File: rtl/camera_move_ctrl.sv
// rtl/camera_move_ctrl.sv - key press/release to coalesced camera move render requests
module camera_move_ctrl #(
    parameter int NUM_KEYS = 6,
    parameter int CNT_W    = 32,
    parameter int STEP     = 3,
    parameter int INIT_AMT = 25,
    parameter int DIR_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    camera_move_ctrl_if.slave  cam
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HELD  = 2'd1,
        S_DRAIN = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    localparam logic [CNT_W:0]   STEP_X = (CNT_W+1)'(STEP);
    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INIT_AMT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [DIR_W-1:0]   dir_q, dir_d;
    logic               rendering_q, rendering_d;
    logic               render_frame_q, render_frame_d;
    logic [DIR_W-1:0]   move_dir_q, move_dir_d;
    logic [CNT_W-1:0]   move_amt_q, move_amt_d;

    logic               key_onehot;
    logic [DIR_W-1:0]   key_idx;
    logic               press_ok;
    logic [CNT_W:0]     sum_x;
    logic [CNT_W-1:0]   acc_ticked;
    logic               issue;

    // Decode the pressed key: one-hot check and index encoding
    always_comb begin
        key_onehot = (cam.key_vec != '0) &&
                     ((cam.key_vec & (cam.key_vec - NUM_KEYS'(1))) == '0);
        key_idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (cam.key_vec[i]) begin
                key_idx = DIR_W'(i);
            end
        end
    end

    assign press_ok = cam.key_pressed && key_onehot;

    // Saturating accumulate: one extra bit catches the overflow
    assign sum_x      = {1'b0, acc_q} + STEP_X;
    assign acc_ticked = sum_x[CNT_W] ? '1 : sum_x[CNT_W-1:0];

    // A request goes out only from HELD/DRAIN with motion pending and the pipeline free
    assign issue = ((state_q == S_HELD) || (state_q == S_DRAIN)) &&
                   !rendering_q && !render_frame_q && (acc_q != '0);

    // Next-state, accumulator and request generation
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        dir_d          = dir_q;
        render_frame_d = issue;
        move_dir_d     = issue ? dir_q : move_dir_q;
        move_amt_d     = issue ? acc_q : move_amt_q;
        rendering_d    = rendering_q;

        if (issue) begin
            rendering_d = 1'b1;
        end else if (rendering_q && cam.rendering_done && !render_frame_q) begin
            rendering_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (press_ok) begin
                    dir_d   = key_idx;
                    acc_d   = INIT_C;
                    state_d = cam.key_released ? S_DRAIN : S_HELD;
                end
            end
            S_HELD: begin
                // On issue the sent amount leaves acc; a coincident tick starts the next one
                if (issue) begin
                    acc_d = cam.tick ? STEP_C : '0;
                end else if (cam.tick) begin
                    acc_d = acc_ticked;
                end
                if (cam.key_released) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (acc_q == '0) begin
                    state_d = S_WAIT;
                end else if (issue) begin
                    acc_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (press_ok) begin
                    dir_d   = key_idx;
                    acc_d   = INIT_C;
                    state_d = S_HELD;
                end else if (!rendering_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            acc_q          <= '0;
            dir_q          <= '0;
            rendering_q    <= 1'b0;
            render_frame_q <= 1'b0;
            move_dir_q     <= '0;
            move_amt_q     <= '0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            dir_q          <= dir_d;
            rendering_q    <= rendering_d;
            render_frame_q <= render_frame_d;
            move_dir_q     <= move_dir_d;
            move_amt_q     <= move_amt_d;
        end
    end

    assign cam.render_frame = render_frame_q;
    assign cam.move_dir     = move_dir_q;
    assign cam.move_amt     = move_amt_q;
    assign cam.busy         = (state_q != S_IDLE) || rendering_q;
endmodule

// File: tb/tb_camera_move_ctrl.sv
// tb/tb_camera_move_ctrl.sv - directed self-checking bench for camera_move_ctrl
module tb_camera_move_ctrl;
    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_cnt   = 0;
    int frame_cnt_s = 0;

    camera_move_ctrl_if #(.NUM_KEYS(6), .CNT_W(32)) kif ();
    camera_move_ctrl_if #(.NUM_KEYS(6), .CNT_W(8))  sif ();

    camera_move_ctrl #(.NUM_KEYS(6), .CNT_W(32), .STEP(3), .INIT_AMT(25)) dut (
        .clk (clk),
        .rst (rst),
        .cam (kif.slave)
    );

    camera_move_ctrl #(.NUM_KEYS(6), .CNT_W(8), .STEP(100), .INIT_AMT(25)) dut_s (
        .clk (clk),
        .rst (rst),
        .cam (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (kif.render_frame) frame_cnt++;
        if (sif.render_frame) frame_cnt_s++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [5:0] vec, input logic rel);
        kif.key_vec      = vec;
        kif.key_pressed  = 1'b1;
        kif.key_released = rel;
        cyc(1);
        kif.key_pressed  = 1'b0;
        kif.key_released = 1'b0;
    endtask

    task automatic release_key();
        kif.key_released = 1'b1;
        cyc(1);
        kif.key_released = 1'b0;
    endtask

    task automatic done_pulse();
        kif.rendering_done = 1'b1;
        cyc(1);
        kif.rendering_done = 1'b0;
    endtask

    task automatic tick_pulse();
        kif.tick = 1'b1;
        cyc(1);
        kif.tick = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        kif.tick = 0; kif.key_pressed = 0; kif.key_released = 0;
        kif.key_vec = '0; kif.rendering_done = 0;
        sif.tick = 0; sif.key_pressed = 0; sif.key_released = 0;
        sif.key_vec = '0; sif.rendering_done = 0;
        cyc(2);
        check("reset_render_frame", 32'(kif.render_frame), 0);
        check("reset_busy", 32'(kif.busy), 0);
        check("reset_move_amt", kif.move_amt, 0);
        check("reset_move_dir", 32'(kif.move_dir), 0);
        rst = 1'b1;
        cyc(2);

        // Tap from an idle pipeline
        frame_cnt = 0;
        press(6'b010000, 1'b1);
        check("tap_busy_after_press", 32'(kif.busy), 1);
        check("tap_no_frame_yet", 32'(kif.render_frame), 0);
        cyc(1);
        check("tap_render_frame", 32'(kif.render_frame), 1);
        check("tap_move_dir", 32'(kif.move_dir), 4);
        check("tap_move_amt", kif.move_amt, 25);
        cyc(1);
        check("tap_pulse_single", 32'(kif.render_frame), 0);
        cyc(3);
        check("tap_frame_count", 32'(frame_cnt), 1);
        check("tap_busy_rendering", 32'(kif.busy), 1);
        done_pulse();
        cyc(1);
        check("tap_busy_cleared", 32'(kif.busy), 0);

        // Hold with the pipeline busy
        frame_cnt = 0;
        press(6'b000001, 1'b0);
        cyc(1);
        check("hold_f1_frame", 32'(kif.render_frame), 1);
        check("hold_f1_dir", 32'(kif.move_dir), 0);
        check("hold_f1_amt", kif.move_amt, 25);
        for (int i = 0; i < 5; i++) begin
            tick_pulse();
            cyc(1);
        end
        check("hold_no_frame_while_rendering", 32'(frame_cnt), 1);
        done_pulse();
        cyc(1);
        check("hold_f2_frame", 32'(kif.render_frame), 1);
        check("hold_f2_amt", kif.move_amt, 15);
        cyc(1);
        release_key();
        cyc(4);
        check("hold_no_third_frame", 32'(frame_cnt), 2);
        check("hold_busy_wait", 32'(kif.busy), 1);
        done_pulse();
        cyc(2);
        check("hold_idle_after_done", 32'(kif.busy), 0);

        // Invalid key vectors
        frame_cnt = 0;
        press(6'b000011, 1'b0);
        check("multi_hot_busy", 32'(kif.busy), 0);
        press(6'b000000, 1'b0);
        check("zero_hot_busy", 32'(kif.busy), 0);
        cyc(4);
        check("invalid_no_frames", 32'(frame_cnt), 0);
        check("invalid_busy", 32'(kif.busy), 0);

        // Saturation on the narrow instance
        frame_cnt_s = 0;
        sif.key_vec = 6'b000010;
        sif.key_pressed = 1'b1;
        cyc(1);
        sif.key_pressed = 1'b0;
        cyc(1);
        check("sat_f1_frame", 32'(sif.render_frame), 1);
        check("sat_f1_amt", 32'(sif.move_amt), 25);
        check("sat_f1_dir", 32'(sif.move_dir), 1);
        for (int i = 0; i < 3; i++) begin
            sif.tick = 1'b1;
            cyc(1);
            sif.tick = 1'b0;
            cyc(1);
        end
        sif.rendering_done = 1'b1;
        cyc(1);
        sif.rendering_done = 1'b0;
        cyc(1);
        check("sat_f2_frame", 32'(sif.render_frame), 1);
        check("sat_f2_amt", 32'(sif.move_amt), 255);
        sif.key_released = 1'b1;
        cyc(1);
        sif.key_released = 1'b0;
        sif.rendering_done = 1'b1;
        cyc(1);
        sif.rendering_done = 1'b0;
        cyc(3);
        check("sat_frame_count", 32'(frame_cnt_s), 2);
        check("sat_idle", 32'(sif.busy), 0);

        // Tick coincident with issue, then press during WAIT
        frame_cnt = 0;
        press(6'b000100, 1'b0);
        kif.tick = 1'b1;
        cyc(1);
        kif.tick = 1'b0;
        check("conc_f1_frame", 32'(kif.render_frame), 1);
        check("conc_f1_amt", kif.move_amt, 25);
        check("conc_f1_dir", 32'(kif.move_dir), 2);
        cyc(1);
        done_pulse();
        cyc(1);
        check("conc_f2_frame", 32'(kif.render_frame), 1);
        check("conc_f2_amt", kif.move_amt, 3);
        cyc(1);
        release_key();
        cyc(2);
        press(6'b100000, 1'b0);
        cyc(2);
        check("conc_wait_press_no_frame", 32'(frame_cnt), 2);
        done_pulse();
        cyc(1);
        check("conc_f3_frame", 32'(kif.render_frame), 1);
        check("conc_f3_dir", 32'(kif.move_dir), 5);
        check("conc_f3_amt", kif.move_amt, 25);
        cyc(1);
        release_key();
        cyc(2);
        done_pulse();
        cyc(2);
        check("conc_idle", 32'(kif.busy), 0);

        // Asynchronous reset while a request is on the outputs
        press(6'b001000, 1'b0);
        cyc(1);
        check("rst_pre_frame", 32'(kif.render_frame), 1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_frame", 32'(kif.render_frame), 0);
        check("rst_async_amt", kif.move_amt, 0);
        check("rst_async_dir", 32'(kif.move_dir), 0);
        check("rst_async_busy", 32'(kif.busy), 0);
        cyc(2);
        rst = 1'b1;
        frame_cnt = 0;
        done_pulse();
        tick_pulse();
        tick_pulse();
        cyc(4);
        check("rst_no_frames_after", 32'(frame_cnt), 0);
        check("rst_idle_after", 32'(kif.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/camera_move_ctrl.md
Name: camera_move_ctrl

Overview:
Parametrised keyboard-to-camera motion controller. It converts key press/release events from the PS/2 key decoder into direction-tagged move amounts and issues render requests to the ray-tracing frame pipeline. It supports NUM_KEYS direction channels. While a key is held it accumulates motion on every frame tick and coalesces the accumulated motion into the next render request. It never issues a new request while a frame is still rendering.

Parameters:
NUM_KEYS, 6, number of direction keys; key index i maps to move direction i.
CNT_W, 32, width of the accumulator and move_amt.
STEP, 3, amount added to the accumulator per tick while a key is held.
INIT_AMT, 25, amount loaded into the accumulator on an accepted press.
DIR_W, $clog2(NUM_KEYS), derived; width of move_dir.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
tick  in  1  single-cycle frame-rate strobe (vsync derived)
key_pressed  in  1  single-cycle press event
key_released  in  1  single-cycle release event
key_vec  in  NUM_KEYS  key identity, sampled with key_pressed; must be one-hot
rendering_done  in  1  single-cycle pulse: current frame finished
render_frame  out  1  single-cycle render request
move_dir  out  DIR_W  direction index for the request, valid while render_frame=1
move_amt  out  CNT_W  motion amount for the request, valid while render_frame=1
busy  out  1  high when state != IDLE or rendering=1

Behaviour:
- Reset (rst=0, async): state=IDLE, acc=0, dir=0, rendering=0, render_frame=0, move_dir=0, move_amt=0, busy=0.
- Internal rendering flag:
  - set on the same edge that drives render_frame high;
  - cleared on the edge after rendering_done=1;
  - rendering_done while rendering=0 is ignored;
  - rendering_done is ignored in the cycle render_frame=1.
- Press validity: a press is accepted only if key_vec is exactly one-hot. Zero-hot or multi-hot presses are ignored: no state or accumulator change.
- Issue condition, evaluated in cycle t: state is HELD or DRAIN, rendering=0, render_frame=0, acc!=0.
  - t+1: render_frame=1, move_dir=dir, move_amt=acc(t), rendering=1.
  - acc(t+1) = STEP if the state is HELD and tick=1 in cycle t; otherwise 0.
- States:
  - IDLE:
    - accepted press: dir=index of key_vec, acc=INIT_AMT, go to HELD;
    - accepted press with key_released in the same cycle (tap): go to DRAIN instead.
  - HELD:
    - tick adds STEP to acc, saturating at 2^CNT_W-1;
    - key_released goes to DRAIN;
    - a press of any key while in HELD is ignored (no key rollover).
  - DRAIN:
    - tick is ignored;
    - if acc!=0, wait for the issue condition, issue, then go to WAIT in the same cycle as the issue;
    - if acc==0, go to WAIT immediately.
  - WAIT:
    - rendering=0 goes to IDLE;
    - an accepted press goes to HELD with the new dir and acc=INIT_AMT (press has priority over rendering=0);
    - the issue condition is re-evaluated from HELD.
- Simultaneous events in HELD:
  - issue and tick in the same cycle: the tick's STEP is not lost (it goes into the next acc);
  - release and tick in the same cycle: the tick still accumulates; then go to DRAIN.
- Arithmetic: STEP and INIT_AMT are zero-extended to CNT_W. Saturation is computed on an addition one bit wider than CNT_W.
- Latency: press to first render_frame is 2 cycles when rendering=0 (t: press accepted; t+1: HELD with acc=INIT_AMT meets the issue condition; t+2: render_frame=1).
- Reset mid-operation: all state, including a pending render_frame pulse, clears immediately. An outstanding rendering_done arriving after reset is ignored.

Test Plan:
1. Reset: assert rst=0 mid-stream with key held -> render_frame, move_amt, move_dir, busy=0 asynchronously; after release of reset, state IDLE, no frames issued without a new press.
2. Tap: idle pipeline; key_pressed+key_released same cycle, key_vec=6'b010000 -> render_frame exactly once, two cycles later, with move_dir=4 and move_amt=25. After rendering_done, busy drops to 0 one cycle later.
3. Hold under load: press key_vec=6'b000001 -> frame #1 with amt 25, dir 0. Issue 5 ticks while rendering, then rendering_done -> frame #2 with amt 15. Release with no further ticks -> no third frame; IDLE after done.
4. Invalid keys: key_pressed with key_vec=6'b000011, then 6'b000000 -> no render_frame, busy stays 0, state IDLE.
5. Saturation: CNT_W=8, STEP=100, INIT_AMT=25, rendering held busy for 3 ticks -> acc saturates; next frame move_amt=255.
6. Concurrency: tick coincident with the issue cycle in HELD -> frame carries the pre-tick acc; the next frame includes that tick's STEP=3. A press during WAIT with key_vec=6'b100000 re-enters HELD with dir=5 and next amt=25.
